ddr_frame_counter: RTL and testbench
====================================

// Module: ddr_frame_counter
// PURPOSE
//   Counts HDR-DDR word frames (20 bits: 2 preamble + 16 data + 2 parity) for the CCC handler.
//   Sits beside the bit counter, downstream of the regfile command fields.
//   Loads the payload byte count for the active command when enabled.
//   Tells the handler when the last frame is on the bus, when the payload is finished,
//   and whether the final word carries an odd (padded) byte.
// PARAMETERS
//   P_LEN_W     16  width of DATA_LENGTH and of the frame/remaining counters
//   P_LAST_BIT  19  bit-counter value of the final bit of one frame
//   P_MAX_IMM   4   maximum immediate payload bytes; larger DTT is clamped to this value
// PORTS
//   i_sys_clk           in   1        system clock
//   i_sys_rst           in   1        synchronous, active-high reset
//   i_frmcnt_en         in   1        level enable from CCC handler; falling = abort or release
//   i_regf_CMD_ATTR     in   3        0 = regular (use DATA_LENGTH), 1 = immediate (use DTT); other values = regular
//   i_regf_DATA_LENGTH  in   P_LEN_W  payload bytes, regular command
//   i_regf_DTT          in   3        payload bytes, immediate command
//   i_bitcnt_number     in   5        current bit index from the bit counter
//   i_scl_pos_edge      in   1        SCL rising-edge strobe, 1 sys clk wide
//   i_scl_neg_edge      in   1        SCL falling-edge strobe, 1 sys clk wide
//   o_frmcnt_busy       out  1        high in COUNT
//   o_frmcnt_last_frame out  1        high while the final frame is in flight
//   o_frmcnt_done       out  1        1-cycle pulse when the payload is complete
//   o_frmcnt_odd        out  1        latched byte count [0]; 1 = last word padded
//   o_frmcnt_remaining  out  P_LEN_W  frames still to transfer, including the current one
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE. Reset applies on the next edge even mid-COUNT.
//   bytes  = (CMD_ATTR==1) ? min(DTT, P_MAX_IMM) : DATA_LENGTH
//   frames = (bytes+1)>>1; the add is P_LEN_W+1 bits wide, so 0xFFFF gives 0x8000.
//   frame_end = i_bitcnt_number==P_LAST_BIT && (i_scl_pos_edge || i_scl_neg_edge)
//   FSM: IDLE, COUNT, DONE. All outputs are registered.
//   IDLE -> en=1:
//     latch bytes, odd=bytes[0], remaining=frames.
//     frames==0: go to DONE and pulse done next cycle.
//     otherwise: go to COUNT with busy=1, last_frame=(frames==1).
//   COUNT, frame_end with remaining>1:
//     remaining-1; last_frame=1 when the new value is 1.
//   COUNT, frame_end with remaining==1:
//     remaining=0, last_frame=0, busy=0, done=1 for 1 cycle, go to DONE.
//   COUNT, en=0: abort to IDLE.
//     Clear remaining, last_frame, busy and odd; no done pulse.
//     Abort wins over a simultaneous frame_end.
//   DONE: hold odd; remaining=0. en=0 -> IDLE. No reload while en stays high.
//   Regfile inputs are sampled only on the IDLE->load cycle; later changes are ignored.
//   frame_end is ignored in IDLE and DONE. remaining never wraps below 0.
// STRUCTURE
//   Shared package ddr_pkg holds:
//     - frmcnt_state_t enum {IDLE, COUNT, DONE}
//     - CMD_ATTR_REGULAR=0 and CMD_ATTR_IMMEDIATE=1
//     - FRAME_LAST_BIT=19
//     - function bytes_to_frames()
//   No sub-module; a single FSM plus the counter.
// TESTING
//   1 Regular, LEN=6, en=1, 3 frame_ends:
//     remaining 3->2->1; last_frame high only during frame 3; done pulse after it; odd=0.
//   2 Regular, LEN=5: remaining=3, odd=1; done after the 3rd frame_end.
//   3 Immediate, DTT=3: remaining=2, odd=1.
//     DTT=7: clamps to 4, remaining=2, odd=0.
//   4 LEN=0: DONE on the cycle after load; done pulses once; busy and last_frame never high.
//   5 LEN=8, drop en after frame 1: IDLE, remaining=0, no done.
//     Re-enable with LEN=2: reloads, remaining=1, last_frame=1.
//   6 LEN=0xFFFF: remaining=0x8000, odd=1.
//     Assert i_sys_rst mid-COUNT: all outputs 0 at the next edge.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and constants for the HDR-DDR frame counter.
// Holds the FSM state enum, CMD_ATTR codes and the byte-to-frame conversion.
package ddr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } frmcnt_state_t;

    localparam logic [2:0] CMD_ATTR_REGULAR   = 3'd0;
    localparam logic [2:0] CMD_ATTR_IMMEDIATE = 3'd1;
    localparam int         FRAME_LAST_BIT     = 19;
    localparam int         LEN_W              = 16;

    // Each 16-bit DDR word carries two bytes; the add is one bit wider so 0xFFFF rounds up to 0x8000.
    function automatic logic [LEN_W-1:0] bytes_to_frames(input logic [LEN_W-1:0] bytes);
        logic [LEN_W:0] sum;
        sum = {1'b0, bytes} + {{LEN_W{1'b0}}, 1'b1};
        return LEN_W'(sum >> 1);
    endfunction

endpackage

// File: rtl/ddr_frame_counter_if.sv
// Signal bundle between the CCC handler / regfile / bit counter and the frame counter.
// The handler drives the master side; the frame counter is the slave.
interface ddr_frame_counter_if
    import ddr_pkg::*;
#(
    parameter int P_LEN_W = 16
);
    // i_frmcnt_en is a level request: the counter loads on the first cycle it is seen high
    // in IDLE and keeps running while it stays high; dropping it aborts or releases.
    logic               i_frmcnt_en;
    logic [2:0]         i_regf_CMD_ATTR;
    logic [P_LEN_W-1:0] i_regf_DATA_LENGTH;
    logic [2:0]         i_regf_DTT;
    logic [4:0]         i_bitcnt_number;
    logic               i_scl_pos_edge;
    logic               i_scl_neg_edge;

    logic               o_frmcnt_busy;
    logic               o_frmcnt_last_frame;
    logic               o_frmcnt_done;
    logic               o_frmcnt_odd;
    logic [P_LEN_W-1:0] o_frmcnt_remaining;
    frmcnt_state_t      o_frmcnt_state;

    modport master (
        output i_frmcnt_en, i_regf_CMD_ATTR, i_regf_DATA_LENGTH, i_regf_DTT,
               i_bitcnt_number, i_scl_pos_edge, i_scl_neg_edge,
        input  o_frmcnt_busy, o_frmcnt_last_frame, o_frmcnt_done, o_frmcnt_odd,
               o_frmcnt_remaining, o_frmcnt_state
    );

    modport slave (
        input  i_frmcnt_en, i_regf_CMD_ATTR, i_regf_DATA_LENGTH, i_regf_DTT,
               i_bitcnt_number, i_scl_pos_edge, i_scl_neg_edge,
        output o_frmcnt_busy, o_frmcnt_last_frame, o_frmcnt_done, o_frmcnt_odd,
               o_frmcnt_remaining, o_frmcnt_state
    );

endinterface

// File: rtl/ddr_frame_counter.sv
// Counts 20-bit HDR-DDR word frames for the active CCC command payload and flags
// the last frame, payload completion and an odd (padded) final byte.
module ddr_frame_counter
    import ddr_pkg::*;
#(
    parameter int P_LEN_W    = 16,
    parameter int P_LAST_BIT = FRAME_LAST_BIT,
    parameter int P_MAX_IMM  = 4
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_rst,
    ddr_frame_counter_if.slave  bus
);

    frmcnt_state_t      r_state;
    logic               r_busy;
    logic               r_last_frame;
    logic               r_done;
    logic               r_odd;
    logic [P_LEN_W-1:0] r_remaining;

    logic               w_imm;
    logic [2:0]         w_dtt_clamped;
    logic [P_LEN_W-1:0] w_bytes;
    logic [P_LEN_W:0]   w_sum;
    logic [P_LEN_W-1:0] w_frames;
    logic               w_frame_end;

    // Only attribute 1 selects the immediate path; every other code is treated as regular.
    always_comb begin
        w_imm         = (bus.i_regf_CMD_ATTR == CMD_ATTR_IMMEDIATE);
        w_dtt_clamped = (bus.i_regf_DTT > 3'(P_MAX_IMM)) ? 3'(P_MAX_IMM) : bus.i_regf_DTT;
        w_bytes       = w_imm ? P_LEN_W'(w_dtt_clamped) : bus.i_regf_DATA_LENGTH;
        w_sum         = {1'b0, w_bytes} + {{P_LEN_W{1'b0}}, 1'b1};
        w_frames      = P_LEN_W'(w_sum >> 1);
        w_frame_end   = (bus.i_bitcnt_number == 5'(P_LAST_BIT)) &&
                        (bus.i_scl_pos_edge || bus.i_scl_neg_edge);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_last_frame <= 1'b0;
            r_done       <= 1'b0;
            r_odd        <= 1'b0;
            r_remaining  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.i_frmcnt_en) begin
                        r_odd       <= w_bytes[0];
                        r_remaining <= w_frames;
                        if (w_frames == '0) begin
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_last_frame <= 1'b0;
                        end else begin
                            r_state      <= COUNT;
                            r_busy       <= 1'b1;
                            r_last_frame <= (w_frames == P_LEN_W'(1));
                        end
                    end
                end
                COUNT: begin
                    // An abort takes priority over a frame ending on the same cycle.
                    if (!bus.i_frmcnt_en) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_last_frame <= 1'b0;
                        r_odd        <= 1'b0;
                        r_remaining  <= '0;
                    end else if (w_frame_end) begin
                        if (r_remaining > P_LEN_W'(1)) begin
                            r_remaining  <= r_remaining - P_LEN_W'(1);
                            r_last_frame <= (r_remaining == P_LEN_W'(2));
                        end else begin
                            r_state      <= DONE;
                            r_remaining  <= '0;
                            r_last_frame <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_remaining <= '0;
                    if (!bus.i_frmcnt_en) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_frmcnt_busy       = r_busy;
    assign bus.o_frmcnt_last_frame = r_last_frame;
    assign bus.o_frmcnt_done       = r_done;
    assign bus.o_frmcnt_odd        = r_odd;
    assign bus.o_frmcnt_remaining  = r_remaining;
    assign bus.o_frmcnt_state      = r_state;

endmodule

// File: tb/tb_ddr_frame_counter.sv
// Bench for ddr_frame_counter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ddr_frame_counter;
    import ddr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddr_frame_counter_if #(.P_LEN_W(16)) u_if ();

    ddr_frame_counter #(
        .P_LEN_W(16), .P_LAST_BIT(19), .P_MAX_IMM(4)
    ) u_dut (
        .i_sys_clk(clk),
        .i_sys_rst(rst),
        .bus(u_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: phase 0 = idle, 1 = transferring, 2 = finished; rem counts frames not yet ended.
    int m_phase = 0;
    int m_rem   = 0;
    int m_odd   = 0;
    int m_done  = 0;

    always @(posedge clk) begin
        int bytes;
        bit fe;
        fe = (u_if.i_bitcnt_number == 5'd19) && (u_if.i_scl_pos_edge || u_if.i_scl_neg_edge);
        m_done = 0;
        if (rst) begin
            m_phase = 0; m_rem = 0; m_odd = 0;
        end else if (m_phase == 0) begin
            if (u_if.i_frmcnt_en) begin
                if (u_if.i_regf_CMD_ATTR == 3'd1)
                    bytes = (u_if.i_regf_DTT > 3'd4) ? 4 : int'(u_if.i_regf_DTT);
                else
                    bytes = int'(u_if.i_regf_DATA_LENGTH);
                m_rem = (bytes + 1) / 2;
                m_odd = bytes % 2;
                if (m_rem == 0) begin m_phase = 2; m_done = 1; end
                else m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!u_if.i_frmcnt_en) begin
                m_phase = 0; m_rem = 0; m_odd = 0;
            end else if (fe) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_phase = 2; m_done = 1; end
            end
        end else begin
            if (!u_if.i_frmcnt_en) m_phase = 0;
        end
        #1;
        check("m_busy",  u_if.o_frmcnt_busy, (m_phase == 1));
        check("m_last",  u_if.o_frmcnt_last_frame, (m_phase == 1 && m_rem == 1));
        check("m_done",  u_if.o_frmcnt_done, m_done);
        check("m_odd",   u_if.o_frmcnt_odd, m_odd);
        check("m_rem",   u_if.o_frmcnt_remaining, m_rem);
        check("m_state", u_if.o_frmcnt_state,
              (m_phase == 0) ? IDLE : (m_phase == 1) ? COUNT : DONE);
    end

    task automatic load(input logic [2:0] attr, input logic [15:0] len, input logic [2:0] dtt);
        u_if.i_regf_CMD_ATTR    = attr;
        u_if.i_regf_DATA_LENGTH = len;
        u_if.i_regf_DTT         = dtt;
        u_if.i_frmcnt_en        = 1'b1;
        @(negedge clk);
    endtask

    task automatic frame_end(input bit use_neg);
        u_if.i_bitcnt_number = 5'd19;
        u_if.i_scl_pos_edge  = !use_neg;
        u_if.i_scl_neg_edge  = use_neg;
        @(negedge clk);
        u_if.i_bitcnt_number = 5'd0;
        u_if.i_scl_pos_edge  = 1'b0;
        u_if.i_scl_neg_edge  = 1'b0;
    endtask

    task automatic release_en();
        u_if.i_frmcnt_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        u_if.i_frmcnt_en        = 1'b0;
        u_if.i_regf_CMD_ATTR    = 3'd0;
        u_if.i_regf_DATA_LENGTH = 16'd0;
        u_if.i_regf_DTT         = 3'd0;
        u_if.i_bitcnt_number    = 5'd0;
        u_if.i_scl_pos_edge     = 1'b0;
        u_if.i_scl_neg_edge     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", u_if.o_frmcnt_busy, 0);
        check("rst_last", u_if.o_frmcnt_last_frame, 0);
        check("rst_done", u_if.o_frmcnt_done, 0);
        check("rst_odd",  u_if.o_frmcnt_odd, 0);
        check("rst_rem",  u_if.o_frmcnt_remaining, 0);
        rst = 1'b0;
        @(negedge clk);

        // Regular LEN=6: three frames, even byte count.
        load(3'd0, 16'd6, 3'd0);
        check("t1_rem3", u_if.o_frmcnt_remaining, 3);
        check("t1_last0", u_if.o_frmcnt_last_frame, 0);
        check("t1_busy", u_if.o_frmcnt_busy, 1);
        check("t1_odd", u_if.o_frmcnt_odd, 0);
        frame_end(1'b0);
        check("t1_rem2", u_if.o_frmcnt_remaining, 2);
        frame_end(1'b0);
        check("t1_rem1", u_if.o_frmcnt_remaining, 1);
        check("t1_last1", u_if.o_frmcnt_last_frame, 1);
        u_if.i_regf_DATA_LENGTH = 16'd100;
        frame_end(1'b0);
        check("t1_done", u_if.o_frmcnt_done, 1);
        check("t1_rem0", u_if.o_frmcnt_remaining, 0);
        check("t1_lastoff", u_if.o_frmcnt_last_frame, 0);
        @(negedge clk);
        check("t1_done_pulse", u_if.o_frmcnt_done, 0);
        repeat (2) @(negedge clk);
        check("t1_no_reload", u_if.o_frmcnt_state, DONE);
        release_en();

        // Regular LEN=5: odd; non-frame-end strobes are ignored; negedge strobe counts.
        load(3'd0, 16'd5, 3'd0);
        check("t2_rem3", u_if.o_frmcnt_remaining, 3);
        check("t2_odd", u_if.o_frmcnt_odd, 1);
        u_if.i_bitcnt_number = 5'd19;
        @(negedge clk);
        u_if.i_bitcnt_number = 5'd7;
        u_if.i_scl_pos_edge  = 1'b1;
        @(negedge clk);
        u_if.i_bitcnt_number = 5'd0;
        u_if.i_scl_pos_edge  = 1'b0;
        check("t2_ignored", u_if.o_frmcnt_remaining, 3);
        frame_end(1'b1);
        frame_end(1'b1);
        frame_end(1'b1);
        check("t2_done", u_if.o_frmcnt_done, 1);
        check("t2_odd_hold", u_if.o_frmcnt_odd, 1);
        release_en();

        // Immediate commands, including DTT clamp and a non-1 attribute treated as regular.
        load(3'd1, 16'd0, 3'd3);
        check("t3_dtt3_rem", u_if.o_frmcnt_remaining, 2);
        check("t3_dtt3_odd", u_if.o_frmcnt_odd, 1);
        release_en();
        load(3'd1, 16'd0, 3'd7);
        check("t3_dtt7_rem", u_if.o_frmcnt_remaining, 2);
        check("t3_dtt7_odd", u_if.o_frmcnt_odd, 0);
        release_en();
        load(3'd5, 16'd3, 3'd7);
        check("t3_attr5_rem", u_if.o_frmcnt_remaining, 2);
        check("t3_attr5_odd", u_if.o_frmcnt_odd, 1);
        release_en();

        // Zero-length payload goes straight to DONE.
        load(3'd0, 16'd0, 3'd0);
        check("t4_state", u_if.o_frmcnt_state, DONE);
        check("t4_done", u_if.o_frmcnt_done, 1);
        check("t4_busy", u_if.o_frmcnt_busy, 0);
        @(negedge clk);
        check("t4_done_once", u_if.o_frmcnt_done, 0);
        release_en();

        // Abort mid-transfer, reload, then abort coinciding with a frame end.
        load(3'd0, 16'd8, 3'd0);
        check("t5_rem4", u_if.o_frmcnt_remaining, 4);
        frame_end(1'b0);
        check("t5_rem3", u_if.o_frmcnt_remaining, 3);
        u_if.i_frmcnt_en = 1'b0;
        @(negedge clk);
        check("t5_abort_state", u_if.o_frmcnt_state, IDLE);
        check("t5_abort_rem", u_if.o_frmcnt_remaining, 0);
        check("t5_abort_done", u_if.o_frmcnt_done, 0);
        load(3'd0, 16'd2, 3'd0);
        check("t5_reload_rem", u_if.o_frmcnt_remaining, 1);
        check("t5_reload_last", u_if.o_frmcnt_last_frame, 1);
        u_if.i_frmcnt_en     = 1'b0;
        u_if.i_bitcnt_number = 5'd19;
        u_if.i_scl_pos_edge  = 1'b1;
        @(negedge clk);
        u_if.i_bitcnt_number = 5'd0;
        u_if.i_scl_pos_edge  = 1'b0;
        check("t5_abort_wins_done", u_if.o_frmcnt_done, 0);
        check("t5_abort_wins_state", u_if.o_frmcnt_state, IDLE);
        release_en();

        // Maximum length, then reset in the middle of counting.
        load(3'd0, 16'hFFFF, 3'd0);
        check("t6_rem", u_if.o_frmcnt_remaining, 32768);
        check("t6_odd", u_if.o_frmcnt_odd, 1);
        frame_end(1'b0);
        check("t6_rem_dec", u_if.o_frmcnt_remaining, 32767);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", u_if.o_frmcnt_busy, 0);
        check("t6_rst_odd", u_if.o_frmcnt_odd, 0);
        check("t6_rst_rem", u_if.o_frmcnt_remaining, 0);
        check("t6_rst_state", u_if.o_frmcnt_state, IDLE);
        rst = 1'b0;
        u_if.i_frmcnt_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
